gate_response_checker: RTL and testbench

Self-checking stimulus/response engine for the two-input primitive gates (Nand, Not, And, Or, Xor). It is the other end of the gate bench interface. It drives a and b through the full truth table, waits for settle, samples the five gate responses and compares them against a golden model. It then reports pass/fail, an error count and a per-gate failure mask. It replaces manual $monitor inspection with a synthesizable checker usable in sim and on the board.

---
 rtl/gate_response_checker_pkg.sv | 35 +++
 rtl/gate_response_checker_if.sv | 24 ++
 rtl/gate_response_checker_expect.sv | 22 ++
 rtl/gate_response_checker.sv | 165 ++++++++++++++++
 tb/tb_gate_response_checker.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/gate_response_checker_pkg.sv
// gate_response_checker_pkg
// Shared definitions for the gate checker family: FSM state encodings,
// gate bit positions in the response vector, sweep size constants and a
// small popcount helper used to tally mismatches.
package gate_response_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int GATE_NAND = 0;
  localparam int GATE_NOT  = 1;
  localparam int GATE_AND  = 2;
  localparam int GATE_OR   = 3;
  localparam int GATE_XOR  = 4;

  localparam int NUM_GATES = 5;
  localparam int NUM_VECS  = 4;

  localparam logic [1:0] LAST_VEC = 2'(NUM_VECS - 1);

  // Number of set bits in a response-mismatch vector (0..5).
  function automatic logic [2:0] count_ones(input logic [NUM_GATES-1:0] bits);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      n = n + {2'b00, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/gate_response_checker_if.sv
// gate_response_checker_if
// Gate bench bus: stimulus a/b toward the gates under test and the five
// gate responses coming back.
//   master : checker side (drives a, b; receives responses)
//   slave  : gate side    (receives a, b; drives responses)
interface gate_response_checker_if;
  logic a;
  logic b;
  logic nand_in;
  logic not_in;
  logic and_in;
  logic or_in;
  logic xor_in;

  modport master (
    output a, b,
    input  nand_in, not_in, and_in, or_in, xor_in
  );

  modport slave (
    input  a, b,
    output nand_in, not_in, and_in, or_in, xor_in
  );
endinterface

// File: rtl/gate_response_checker_expect.sv
// gate_expect
// Combinational golden model for the two-input primitive gates.
//   a, b     : stimulus bits
//   exp_resp : expected responses, bit order given by the GATE_* indices
module gate_expect
  import gate_response_checker_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] exp_resp
);

  always_comb begin
    exp_resp            = '0;
    exp_resp[GATE_NAND] = ~(a & b);
    exp_resp[GATE_NOT]  = ~a;
    exp_resp[GATE_AND]  = a & b;
    exp_resp[GATE_OR]   = a | b;
    exp_resp[GATE_XOR]  = a ^ b;
  end

endmodule

// File: rtl/gate_response_checker.sv
// gate_response_checker
// Sweeps a/b through 00,01,10,11, holds each vector for SETTLE_CYCLES
// cycles, samples the five gate responses for one CHECK cycle and compares
// them with gate_expect. Reports a saturating error count, a sticky
// per-gate failure mask and pass/done status.
//   clock, reset : system clock, synchronous active-high reset
//   start        : one-cycle pulse, accepted in IDLE or DONE
//   gate_bus     : stimulus out / responses in (master modport)
//   vec          : current vector {a,b}
//   busy, done   : sweep running / sweep finished (held)
//   pass         : valid with done, no mismatches seen
//   err_count    : total mismatches, saturates at all-ones
//   fail_mask    : sticky per-gate mismatch bits
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | waiting for start after reset
// SETTLE | vector applied, settle timer running
// CHECK  | one cycle: sample responses, accumulate, advance
// DONE   | results held, start restarts the sweep
module gate_response_checker
  import gate_response_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  gate_response_checker_if.master      gate_bus,
  output logic [1:0]                   vec,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [ERR_W-1:0]             err_count,
  output logic [NUM_GATES-1:0]         fail_mask
);

  // Settle timer is a down-counter; loading S-1 and leaving at zero gives
  // exactly S cycles in SETTLE.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  // Headroom of three bits covers adding up to five mismatches before the
  // saturation compare.
  localparam int                SUM_W   = ERR_W + 3;
  localparam logic [SUM_W-1:0]  ERR_MAX = {3'b000, {ERR_W{1'b1}}};

  state_e                 state_q, state_d;
  logic [1:0]             vec_q, vec_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [ERR_W-1:0]       err_q, err_d;
  logic [NUM_GATES-1:0]   mask_q, mask_d;

  logic [NUM_GATES-1:0]   exp_resp;
  logic [NUM_GATES-1:0]   resp;
  logic [NUM_GATES-1:0]   mismatch;
  logic [SUM_W-1:0]       err_sum;
  logic [ERR_W-1:0]       err_acc;

  gate_expect u_expect (
    .a        (vec_q[1]),
    .b        (vec_q[0]),
    .exp_resp (exp_resp)
  );

  always_comb begin
    resp            = '0;
    resp[GATE_NAND] = gate_bus.nand_in;
    resp[GATE_NOT]  = gate_bus.not_in;
    resp[GATE_AND]  = gate_bus.and_in;
    resp[GATE_OR]   = gate_bus.or_in;
    resp[GATE_XOR]  = gate_bus.xor_in;
  end

  assign mismatch = resp ^ exp_resp;
  assign err_sum  = {3'b000, err_q} + SUM_W'(count_ones(mismatch));
  assign err_acc  = (err_sum > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : err_sum[ERR_W-1:0];

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_SETTLE;
      ST_SETTLE:        if (cnt_q == 4'd0) state_d = ST_CHECK;
      ST_CHECK:         state_d = (vec_q == LAST_VEC) ? ST_DONE : ST_SETTLE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Next values of registered outputs, timer and accumulators
  always_comb begin
    vec_d  = vec_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
    err_d  = err_q;
    mask_d = mask_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          vec_d  = '0;
          cnt_d  = SETTLE_LOAD;
          busy_d = 1'b1;
          done_d = 1'b0;
          pass_d = 1'b0;
          err_d  = '0;
          mask_d = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
      ST_CHECK: begin
        err_d  = err_acc;
        mask_d = mask_q | mismatch;
        if (vec_q == LAST_VEC) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_acc == '0);
        end else begin
          vec_d = vec_q + 2'd1;
          cnt_d = SETTLE_LOAD;
        end
      end
      default: ;
    endcase
  end

  assign gate_bus.a = vec_q[1];
  assign gate_bus.b = vec_q[0];
  assign vec        = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_mask  = mask_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker
// Directed bench for gate_response_checker with SETTLE_CYCLES=2. The gate
// side is a small behavioural model with selectable faults and an optional
// glitch that corrupts responses outside the CHECK cycles.
module tb_gate_response_checker;

  logic       clock;
  logic       reset;
  logic       start;
  logic [1:0] vec;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic [4:0] fail_mask;

  int         fault;   // 0 good, 1 nand stuck 0, 2 xor->or, 3 all inverted
  logic       glitch;
  logic [4:0] resp;

  int n_checks;
  int n_errors;

  gate_response_checker_if gb ();

  gate_response_checker #(
    .SETTLE_CYCLES (2),
    .ERR_W         (5)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .gate_bus  (gb),
    .vec       (vec),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_mask (fail_mask)
  );

  always_comb begin
    resp    = '0;
    resp[0] = ~(gb.a & gb.b);
    resp[1] = ~gb.a;
    resp[2] = gb.a & gb.b;
    resp[3] = gb.a | gb.b;
    resp[4] = gb.a ^ gb.b;
    case (fault)
      1:       resp[0] = 1'b0;
      2:       resp[4] = gb.a | gb.b;
      3:       resp    = ~resp;
      default: ;
    endcase
    if (glitch) resp = ~resp;
  end

  assign gb.nand_in = resp[0];
  assign gb.not_in  = resp[1];
  assign gb.and_in  = resp[2];
  assign gb.or_in   = resp[3];
  assign gb.xor_in  = resp[4];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Starts a sweep in the current cycle (cycle 0) and returns in cycle 13.
  task automatic run_sweep(input string tag, input bit glitch_settle, input bit trace_ab,
                           input int extra_start, output int err12);
    err12 = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      glitch = glitch_settle && ((c % 3) != 0);
      start  = (c == extra_start);
      if (c == 1) begin
        check_val({tag, "_c1_busy"}, busy, 1);
        check_val({tag, "_c1_done"}, done, 0);
        check_val({tag, "_c1_err"}, err_count, 0);
        check_val({tag, "_c1_mask"}, fail_mask, 0);
        check_val({tag, "_c1_vec"}, vec, 0);
      end
      if (trace_ab) check_val({tag, "_ab_seq"}, {gb.a, gb.b}, (c - 1) / 3);
      if (c == 12) begin
        check_val({tag, "_c12_busy"}, busy, 1);
        check_val({tag, "_c12_done"}, done, 0);
        err12 = int'(err_count);
      end
      step();
    end
    glitch = 1'b0;
    start  = 1'b0;
  endtask

  initial begin
    int e12;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    start    = 1'b0;
    fault    = 0;
    glitch   = 1'b0;
    step();
    step();

    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_pass", pass, 0);
    check_val("rst_err", err_count, 0);
    check_val("rst_mask", fail_mask, 0);
    check_val("rst_vec", vec, 0);
    check_val("rst_ab", {gb.a, gb.b}, 0);
    reset = 1'b0;
    step();
    check_val("idle_busy", busy, 0);

    // Good gates, with glitches outside CHECK that must not count
    fault = 0;
    run_sweep("good", 1'b1, 1'b0, -1, e12);
    check_val("good_done", done, 1);
    check_val("good_pass", pass, 1);
    check_val("good_busy", busy, 0);
    check_val("good_err", err_count, 0);
    check_val("good_mask", fail_mask, 5'b00000);
    check_val("good_vec", vec, 3);
    check_val("good_ab", {gb.a, gb.b}, 2'b11);

    // Nand stuck at 0
    fault = 1;
    run_sweep("nand0", 1'b0, 1'b0, -1, e12);
    check_val("nand0_done", done, 1);
    check_val("nand0_err", err_count, 3);
    check_val("nand0_mask", fail_mask, 5'b00001);
    check_val("nand0_pass", pass, 0);

    // Xor replaced with Or: only vector 11 fails, recorded after cycle 12
    fault = 2;
    run_sweep("xoror", 1'b0, 1'b0, -1, e12);
    check_val("xoror_err_c12", e12, 0);
    check_val("xoror_err", err_count, 1);
    check_val("xoror_mask", fail_mask, 5'b10000);
    check_val("xoror_pass", pass, 0);

    // All responses inverted, plus a/b sequence trace
    fault = 3;
    run_sweep("inv", 1'b0, 1'b1, -1, e12);
    check_val("inv_err", err_count, 20);
    check_val("inv_mask", fail_mask, 5'b11111);
    check_val("inv_pass", pass, 0);

    // start during sweep ignored; restart from DONE at cycle 15
    fault = 1;
    run_sweep("busy_start", 1'b0, 1'b0, 5, e12);
    check_val("busy_start_done13", done, 1);
    check_val("busy_start_err", err_count, 3);
    step();
    step();
    run_sweep("restart", 1'b0, 1'b0, -1, e12);
    check_val("restart_done28", done, 1);
    check_val("restart_err", err_count, 3);
    check_val("restart_mask", fail_mask, 5'b00001);

    // Reset mid-sweep at cycle 7
    fault = 3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 7; c++) step();
    check_val("mid_err_c7", err_count, 10);
    reset = 1'b1;
    step();
    check_val("mrst_busy", busy, 0);
    check_val("mrst_ab", {gb.a, gb.b}, 0);
    check_val("mrst_err", err_count, 0);
    check_val("mrst_mask", fail_mask, 0);
    check_val("mrst_done", done, 0);
    check_val("mrst_vec", vec, 0);

    // Reset and start together: start is lost
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    check_val("rst_start_busy", busy, 0);
    step();
    check_val("rst_start_lost", busy, 0);

    fault = 0;
    run_sweep("post_rst", 1'b0, 1'b0, -1, e12);
    check_val("post_rst_done", done, 1);
    check_val("post_rst_pass", pass, 1);
    check_val("post_rst_err", err_count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
